// File: rtl/lvds_rx_mem_writer_if.sv
// ---------------------------------------------------------------------------
// lvds_rx_mem_writer_if
//   Bundles the byte stream coming from the LVDS deserializer and the
//   Avalon-MM write port toward the on-chip memory.
//
//   Handshake: a byte transfers on a rising edge where in_valid and in_ready
//   are both 1. in_sop/in_eop/in_data are meaningful only while in_valid is 1.
//   The source must hold a refused byte (and its flags) until accepted.
//   The memory port has no waitrequest: every mem_write cycle is one write.
//
//   Signals:
//     in_data[7:0], in_valid, in_sop, in_eop  stream source -> packer
//     in_ready                                packer -> stream source
//     mem_address[ADDR_W-1:0], mem_byteenable[3:0], mem_chipselect,
//     mem_write, mem_writedata[31:0], mem_clken  packer -> memory
//
//   Modports:
//     master : environment side (drives the stream, observes the memory port)
//     slave  : packer side
// ---------------------------------------------------------------------------
interface lvds_rx_mem_writer_if #(
    parameter int ADDR_W = 13
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_sop;
    logic              in_eop;
    logic              in_ready;

    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;

    modport master (
        output in_data, in_valid, in_sop, in_eop,
        input  in_ready,
        input  mem_address, mem_byteenable, mem_chipselect,
        input  mem_write, mem_writedata, mem_clken
    );

    modport slave (
        input  in_data, in_valid, in_sop, in_eop,
        output in_ready,
        output mem_address, mem_byteenable, mem_chipselect,
        output mem_write, mem_writedata, mem_clken
    );
endinterface

// File: rtl/lvds_rx_mem_writer.sv
// ---------------------------------------------------------------------------
// lvds_rx_mem_writer
//   Packs a framed 8-bit stream little-endian into 32-bit words and writes
//   each word to on-chip memory with a single-cycle write, starting every
//   frame at word address BASE_ADDR and wrapping at DEPTH.
//
//   Ports:
//     clk, reset     single clock, synchronous active-high reset
//     bus            stream input + memory write port (slave modport)
//     frame_done     one-cycle pulse after a good frame's eop
//     frame_bytes    byte count of the last completed frame (saturating)
//     overflow       sticky: current/last frame wrapped the address space
//     sop_err        sticky: a sop arrived mid-frame (reset clears)
//     state_dbg      current FSM state (IDLE=0, RECV=1, DONE=2)
// ---------------------------------------------------------------------------
module lvds_rx_mem_writer #(
    parameter int ADDR_W    = 13,
    parameter int DEPTH     = 8192,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    lvds_rx_mem_writer_if.slave  bus,
    output logic                 frame_done,
    output logic [15:0]          frame_bytes,
    output logic                 overflow,
    output logic                 sop_err,
    output logic [1:0]           state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
    localparam bit                BASE_IS_LAST = (BASE_ADDR == DEPTH - 1);
    // Address following a one-byte frame's write at BASE_ADDR.
    localparam logic [ADDR_W-1:0] BASE_NEXT = BASE_IS_LAST ? '0 : ADDR_W'(BASE_ADDR + 1);

    logic [1:0]        state;
    logic [1:0]        lane;
    logic [31:0]       acc;        // partial word; unfilled lanes kept at 0
    logic [ADDR_W-1:0] addr;
    logic [15:0]       byte_cnt;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;
    logic [15:0]       frame_bytes_q;
    logic              overflow_q;
    logic              sop_err_q;

    logic              accept;
    logic [31:0]       byte_word;
    logic [31:0]       merged;
    logic [15:0]       cnt_inc;
    logic [ADDR_W-1:0] addr_next;

    function automatic logic [3:0] lane_mask(input logic [1:0] l);
        case (l)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            2'd2:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    // DONE is the only state that refuses bytes.
    assign bus.in_ready = (state != S_DONE);
    assign accept       = bus.in_valid & bus.in_ready;

    assign byte_word = {24'd0, bus.in_data};
    assign merged    = acc | (byte_word << {lane, 3'b000});
    assign cnt_inc   = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
    assign addr_next = (addr == LAST_A) ? '0 : addr + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            lane          <= 2'd0;
            acc           <= 32'd0;
            addr          <= BASE_A;
            byte_cnt      <= 16'd0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= 32'd0;
            wr_be         <= 4'd0;
            frame_bytes_q <= 16'd0;
            overflow_q    <= 1'b0;
            sop_err_q     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE, S_RECV: begin
                    if (accept) begin
                        if (bus.in_sop) begin
                            // A sop always (re)starts a frame; any partial word
                            // of an interrupted frame is simply overwritten.
                            if (state == S_RECV) sop_err_q <= 1'b1;
                            byte_cnt <= 16'd1;
                            if (bus.in_eop) begin
                                wr_en         <= 1'b1;
                                wr_addr       <= BASE_A;
                                wr_data       <= byte_word;
                                wr_be         <= 4'b0001;
                                addr          <= BASE_NEXT;
                                overflow_q    <= BASE_IS_LAST;
                                acc           <= 32'd0;
                                lane          <= 2'd0;
                                frame_bytes_q <= 16'd1;
                                state         <= S_DONE;
                            end else begin
                                acc        <= byte_word;
                                lane       <= 2'd1;
                                addr       <= BASE_A;
                                overflow_q <= 1'b0;
                                state      <= S_RECV;
                            end
                        end else if (state == S_RECV) begin
                            byte_cnt <= cnt_inc;
                            if (bus.in_eop || lane == 2'd3) begin
                                wr_en   <= 1'b1;
                                wr_addr <= addr;
                                wr_data <= merged;
                                wr_be   <= lane_mask(lane);
                                addr    <= addr_next;
                                if (addr == LAST_A) overflow_q <= 1'b1;
                                acc     <= 32'd0;
                                lane    <= 2'd0;
                                if (bus.in_eop) begin
                                    // Loaded here so the count is already
                                    // visible during the frame_done cycle.
                                    frame_bytes_q <= cnt_inc;
                                    state         <= S_DONE;
                                end
                            end else begin
                                acc  <= merged;
                                lane <= lane + 2'd1;
                            end
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_address    = wr_addr;
    assign bus.mem_byteenable = wr_be;
    assign bus.mem_write      = wr_en;
    assign bus.mem_chipselect = wr_en;
    assign bus.mem_writedata  = wr_data;
    assign bus.mem_clken      = 1'b1;

    assign frame_done  = (state == S_DONE);
    assign frame_bytes = frame_bytes_q;
    assign overflow    = overflow_q;
    assign sop_err     = sop_err_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_lvds_rx_mem_writer.sv
// ---------------------------------------------------------------------------
// tb_lvds_rx_mem_writer
//   Two packers share one stimulus stream: A uses the default geometry
//   (8192 words, base 0), B a tiny 4-word memory based at word 2 so that
//   address wrap and overflow occur on ordinary frames. A frame-level
//   model turns each accepted byte into expected writes and status values.
// ---------------------------------------------------------------------------
module tb_lvds_rx_mem_writer;

    localparam int AW_A = 13, DEPTH_A = 8192, BASE_A = 0;
    localparam int AW_B = 2,  DEPTH_B = 4,    BASE_B = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lvds_rx_mem_writer_if #(.ADDR_W(AW_A)) bus_a ();
    lvds_rx_mem_writer_if #(.ADDR_W(AW_B)) bus_b ();

    logic        fd_a, fd_b, ov_a, ov_b, se_a, se_b;
    logic [15:0] fb_a, fb_b;
    logic [1:0]  st_a, st_b;

    lvds_rx_mem_writer #(.ADDR_W(AW_A), .DEPTH(DEPTH_A), .BASE_ADDR(BASE_A)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a),
        .frame_done(fd_a), .frame_bytes(fb_a), .overflow(ov_a),
        .sop_err(se_a), .state_dbg(st_a)
    );

    lvds_rx_mem_writer #(.ADDR_W(AW_B), .DEPTH(DEPTH_B), .BASE_ADDR(BASE_B)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b),
        .frame_done(fd_b), .frame_bytes(fb_b), .overflow(ov_b),
        .sop_err(se_b), .state_dbg(st_b)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // Expected write entry: {address(13), data(32), byteenable(4)}
    logic [48:0] exp_wa[$];
    logic [48:0] exp_wb[$];

    bit          m_in_frame = 1'b0;
    logic [7:0]  m_pend[$];
    int          m_words = 0;
    int          m_cnt = 0;
    bit          m_sop_err = 1'b0;
    int          m_fbytes = 0;
    bit          m_ovf_a = 1'b0;
    bit          m_ovf_b = 1'b0;
    bit          m_done_pending = 1'b0;

    function automatic void model_reset();
        m_in_frame = 1'b0;
        m_pend.delete();
        m_words = 0;
        m_cnt = 0;
        m_sop_err = 1'b0;
        m_fbytes = 0;
        m_ovf_a = 1'b0;
        m_ovf_b = 1'b0;
        m_done_pending = 1'b0;
    endfunction

    function automatic void model_accept(input bit sop, input bit eop, input logic [7:0] d);
        logic [31:0] word;
        logic [3:0]  be;
        int          addr_a, addr_b;
        if (sop) begin
            if (m_in_frame) m_sop_err = 1'b1;
            m_in_frame = 1'b1;
            m_pend.delete();
            m_words = 0;
            m_cnt = 0;
            m_ovf_a = 1'b0;
            m_ovf_b = 1'b0;
        end else if (!m_in_frame) begin
            return;
        end
        m_pend.push_back(d);
        if (m_cnt < 65535) m_cnt++;
        if (m_pend.size() == 4 || eop) begin
            word = 32'd0;
            foreach (m_pend[k]) word = word | (32'(m_pend[k]) << (8 * k));
            be = 4'((1 << m_pend.size()) - 1);
            addr_a = (BASE_A + m_words) % DEPTH_A;
            addr_b = (BASE_B + m_words) % DEPTH_B;
            exp_wa.push_back({13'(addr_a), word, be});
            exp_wb.push_back({13'(addr_b), word, be});
            m_words++;
            // Writing address DEPTH-1 at any point of the frame marks a wrap.
            if (BASE_A + m_words >= DEPTH_A) m_ovf_a = 1'b1;
            if (BASE_B + m_words >= DEPTH_B) m_ovf_b = 1'b1;
            m_pend.delete();
        end
        if (eop) begin
            m_fbytes = m_cnt;
            m_in_frame = 1'b0;
            m_done_pending = 1'b1;
        end
    endfunction

    // ---------------- monitor ----------------
    task automatic check_side(input string tag, input bit is_b,
                              input logic mw, input logic cs, input logic ck,
                              input logic rdy, input logic fd, input logic ov,
                              input logic se, input logic [12:0] ma,
                              input logic [31:0] md, input logic [3:0] mbe,
                              input logic [15:0] fb);
        logic [48:0] e;
        check({tag, "_chipselect"}, 64'(cs), 64'(mw));
        check({tag, "_clken"}, 64'(ck), 64'd1);
        if (mw === 1'b1) begin
            if ((is_b ? exp_wb.size() : exp_wa.size()) == 0) begin
                check({tag, "_unexpected_write"}, {15'd0, ma, md, mbe}, 64'd0);
            end else begin
                e = is_b ? exp_wb.pop_front() : exp_wa.pop_front();
                check({tag, "_write"}, {15'd0, ma, md, mbe}, 64'(e));
            end
        end
        check({tag, "_frame_done"}, 64'(fd), 64'(m_done_pending));
        check({tag, "_in_ready"}, 64'(rdy), 64'(!m_done_pending));
        check({tag, "_frame_bytes"}, 64'(fb), 64'(m_fbytes));
        check({tag, "_overflow"}, 64'(ov), 64'(is_b ? m_ovf_b : m_ovf_a));
        check({tag, "_sop_err"}, 64'(se), 64'(m_sop_err));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_side("a", 1'b0, bus_a.mem_write, bus_a.mem_chipselect, bus_a.mem_clken,
                       bus_a.in_ready, fd_a, ov_a, se_a, 13'(bus_a.mem_address),
                       bus_a.mem_writedata, bus_a.mem_byteenable, fb_a);
            check_side("b", 1'b1, bus_b.mem_write, bus_b.mem_chipselect, bus_b.mem_clken,
                       bus_b.in_ready, fd_b, ov_b, se_b, 13'(bus_b.mem_address),
                       bus_b.mem_writedata, bus_b.mem_byteenable, fb_b);
            m_done_pending = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    logic [7:0] frame_q[$];

    task automatic drive(input logic v, input logic s, input logic e, input logic [7:0] d);
        bus_a.in_valid = v; bus_a.in_sop = s; bus_a.in_eop = e; bus_a.in_data = d;
        bus_b.in_valid = v; bus_b.in_sop = s; bus_b.in_eop = e; bus_b.in_data = d;
    endtask

    // Starts and ends on a falling edge.
    task automatic send_byte(input bit sop, input bit eop, input logic [7:0] d, input int gap);
        int tries;
        repeat (gap) begin
            drive(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
            @(posedge clk);
            @(negedge clk);
        end
        drive(1'b1, sop, eop, d);
        tries = 0;
        while (bus_a.in_ready !== 1'b1 && tries < 8) begin
            @(posedge clk);
            @(negedge clk);
            tries++;
        end
        if (tries >= 8) begin
            check("ready_timeout", 64'(bus_a.in_ready), 64'd1);
            drive(1'b0, 1'b0, 1'b0, 8'd0);
            return;
        end
        @(posedge clk);
        model_accept(sop, eop, d);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic send_frame(input bit with_eop, input int gap, input bit rand_gap);
        int g;
        for (int i = 0; i < frame_q.size(); i++) begin
            g = (i == 0) ? 0 : (rand_gap ? int'($urandom_range(0, gap)) : gap);
            send_byte(i == 0, with_eop && (i == frame_q.size() - 1), frame_q[i], g);
        end
    endtask

    task automatic fill_seq(input int len, input logic [7:0] first);
        frame_q.delete();
        for (int i = 0; i < len; i++) frame_q.push_back(first + 8'(i));
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        @(posedge clk);
        model_reset();
        repeat (cycles - 1) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int len, kind;
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        @(posedge clk);
        @(posedge clk);
        mon_en = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_state_a", 64'(st_a), 64'd0);
        check("rst_state_b", 64'(st_b), 64'd0);
        check("rst_mem_write", 64'(bus_a.mem_write), 64'd0);
        check("rst_mem_address_a", 64'(bus_a.mem_address), 64'd0);
        check("rst_mem_address_b", 64'(bus_b.mem_address), 64'd0);
        check("rst_mem_writedata", 64'(bus_a.mem_writedata), 64'd0);
        check("rst_mem_byteenable", 64'(bus_a.mem_byteenable), 64'd0);
        check("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
        reset = 1'b0;

        // 8-byte frame, valid every cycle
        fill_seq(8, 8'h01);
        send_frame(1'b1, 0, 1'b0);
        idle(2);
        check("f8_frame_bytes", 64'(fb_a), 64'd8);
        check("f8_overflow_b", 64'(ov_b), 64'd1);

        // 5-byte frame with 3-cycle gaps
        fill_seq(5, 8'hA0);
        send_frame(1'b1, 3, 1'b0);

        // Single byte, presented while DONE so it must be held
        frame_q.delete();
        frame_q.push_back(8'h5A);
        send_frame(1'b1, 0, 1'b0);
        idle(1);
        check("f5_then_f1_frame_bytes", 64'(fb_a), 64'd1);
        check("f1_state_idle", 64'(st_a), 64'd0);

        // 20-byte frame: B writes 2,3,0,1,2
        fill_seq(20, 8'h30);
        send_frame(1'b1, 0, 1'b0);
        check("wrap_overflow_done_b", 64'(ov_b), 64'd1);
        idle(2);

        // Mid-frame sop: 6 bytes, then a fresh 4-byte frame
        fill_seq(6, 8'h60);
        send_frame(1'b0, 0, 1'b0);
        check("abort_overflow_cleared_b", 64'(ov_b), 64'd0);
        fill_seq(4, 8'hC0);
        send_frame(1'b1, 1, 1'b0);
        idle(1);
        check("abort_sop_err", 64'(se_a), 64'd1);
        check("abort_frame_bytes", 64'(fb_a), 64'd4);

        // Reset after 2 bytes, then pre-sop bytes, then a good frame
        fill_seq(2, 8'h10);
        send_frame(1'b0, 0, 1'b0);
        do_reset(1);
        check("mid_rst_sop_err", 64'(se_a), 64'd0);
        check("mid_rst_state", 64'(st_a), 64'd0);
        send_byte(1'b0, 1'b0, 8'hEE, 0);
        send_byte(1'b0, 1'b1, 8'hEF, 1);
        fill_seq(4, 8'h21);
        send_frame(1'b1, 0, 1'b0);
        idle(1);
        check("post_rst_frame_bytes", 64'(fb_a), 64'd4);

        // Randomized frames: junk, aborts, mid-frame resets, random gaps
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++)
                    send_byte(1'b0, 1'($urandom), 8'($urandom), int'($urandom_range(0, 1)));
            end
            len = int'($urandom_range(1, 14));
            kind = int'($urandom_range(0, 9));
            frame_q.delete();
            for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
            send_frame(kind > 1, 2, 1'b1);
            if (kind == 1) do_reset(int'($urandom_range(1, 2)));
        end
        fill_seq(3, 8'h77);
        send_frame(1'b1, 0, 1'b0);

        // Drain
        idle(4);
        check("drain_writes_a", 64'(exp_wa.size()), 64'd0);
        check("drain_writes_b", 64'(exp_wb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
